// File: rtl/result_streamer_pkg.sv
// Shared definitions for the result streamer: default geometry and FSM encoding.
package result_streamer_pkg;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_NUM_WORDS = 16;
  localparam int unsigned DEF_ADDR_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/fifo2.sv
// Two-entry FIFO holding result words between the buffer read port and the
// output handshake. A push into a full FIFO is accepted only alongside a pop.
module fifo2
  import result_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage write.
  // NOTE: the data array is deliberately left without reset; it is only ever
  // observed through a non-empty head, and emptiness is reset above.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/result_streamer.sv
// Streams NUM_WORDS result words from a one-cycle-latency buffer to a
// valid/ready consumer once per rising edge of the controller's done level.
module result_streamer
  import result_streamer_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
  parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic              clear,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              finished
);

  // Counters are one bit wider than the address so they can hold NUM_WORDS.
  localparam logic [ADDR_W:0] WORDS     = (ADDR_W+1)'(NUM_WORDS);
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(NUM_WORDS - 1);

  state_t          state;
  state_t          state_nx;
  logic            done_q;
  logic            armed;
  logic            trigger;
  logic            in_flight;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] word_cnt;
  logic            run;
  logic            pop;
  logic            push;
  logic            fifo_full;
  logic            fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [1:0]      occupancy;
  logic [2:0]      pending;

  // armed stays low after reset until done has been seen low, so a done level
  // still high from before the reset cannot start a pass.
  assign trigger   = done & ~done_q & armed;
  assign run       = (state == RUN);
  assign out_valid = run & ~fifo_empty;
  assign out_data  = out_valid ? fifo_head : '0;
  assign out_last  = out_valid & (word_cnt == LAST_WORD);
  assign pop       = out_valid & out_ready;
  assign push      = in_flight & run & ~clear;
  assign occupancy = {fifo_full, ~fifo_full & ~fifo_empty};
  assign pending   = {1'b0, occupancy} + {2'b0, in_flight} - {2'b0, pop};
  assign rd_en     = run & ~clear & (rd_ptr < WORDS) & (pending < 3'd2);
  assign rd_addr   = rd_ptr[ADDR_W-1:0];
  assign busy      = run;
  assign finished  = (state == FIN);

  fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rd_data),
    .pop       (pop),
    .flush     (clear),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Next-state logic; clear outranks both the trigger and the final transfer.
  always_comb begin
    // NOTE: state_nx gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nx = state;
    case (state)
      IDLE:    if (!clear && trigger)   state_nx = RUN;
      RUN:     if (clear)               state_nx = IDLE;
               else if (pop && out_last) state_nx = FIN;
      FIN:     if (clear)               state_nx = IDLE;
      default:                          state_nx = IDLE;
    endcase
  end

  // State, edge detector, in-flight tracking and the saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments throughout, so every register here sees
    // the pre-edge value of the others regardless of statement order.
    if (!rst) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      armed     <= 1'b0;
      in_flight <= 1'b0;
      rd_ptr    <= '0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nx;
      done_q    <= done;
      armed     <= armed | ~done;
      in_flight <= rd_en;
      if (!run || clear) begin
        rd_ptr   <= '0;
        word_cnt <= '0;
      end else begin
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        if (pop && word_cnt != WORDS) word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule
